// File: rtl/spmv_pkg.sv
// Shared state encoding and default widths for the SpMV fetch/reduce datapath.
package spmv_pkg;

    localparam int ELE_W_DEF = 32;
    localparam int ACC_W_DEF = 48;
    localparam int ROW_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        EMIT,
        DONE
    } reducer_state_t;

endpackage

// File: rtl/spmv_len_fifo.sv
// Row-length FIFO: synchronous push/pop with a flush that wins over both.
// Push is ignored when full and pop when empty; simultaneous push+pop keeps occupancy.
import spmv_pkg::*;

module spmv_len_fifo #(
    parameter int W     = ELE_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spmv_row_reducer.sv
// Accumulates signed products per row and emits one y[row] per row, in row order.
// SPMV_REDUCER_SAT_EN selects saturating additions with a sticky ovf; otherwise sums wrap.
import spmv_pkg::*;

module spmv_row_reducer #(
    parameter int ELE_W     = ELE_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int LEN_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [ROW_W-1:0] nr,
    input  logic             len_val,
    output logic             len_rdy,
    input  logic [ELE_W-1:0] len_data,
    input  logic             prod_val,
    output logic             prod_rdy,
    input  logic [ELE_W-1:0] prod_data,
    output logic             y_val,
    input  logic             y_rdy,
    output logic [ACC_W-1:0] y_data,
    output logic [ROW_W-1:0] y_row,
    output logic             y_last,
    output logic             done,
    output logic             ovf
);

    reducer_state_t   state_q, state_d;
    logic [ROW_W-1:0] nr_q, nr_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [ELE_W-1:0] remaining_q, remaining_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [ELE_W-1:0] fifo_dout;
    logic [ACC_W-1:0] prod_sx, add_res;
    logic             clamp;
    logic [ROW_W-1:0] nr_last;

    spmv_len_fifo #(
        .W     (ELE_W),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (init),
        .push  (len_val),
        .din   (len_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign prod_sx = ACC_W'($signed(prod_data));
    assign nr_last = nr_q - 1'b1;

`ifdef SPMV_REDUCER_SAT_EN
    logic [ACC_W:0] sum_ext;
    // One guard bit: a guard/sign disagreement means the true sum left the ACC_W range.
    assign sum_ext = {acc_q[ACC_W-1], acc_q} + {prod_sx[ACC_W-1], prod_sx};
    assign clamp   = (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
    assign add_res = !clamp ? sum_ext[ACC_W-1:0]
                   : (sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}});
`else
    assign add_res = acc_q + prod_sx;
    assign clamp   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        nr_d        = nr_q;
        row_idx_d   = row_idx_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        fifo_pop    = 1'b0;
        prod_rdy    = 1'b0;
        y_val       = 1'b0;
        if (init) begin
            state_d     = IDLE;
            nr_d        = nr;
            row_idx_d   = '0;
            remaining_d = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (nr_q == '0) ? DONE : LOAD;
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        remaining_d = fifo_dout;
                        acc_d       = '0;
                        state_d     = (fifo_dout == '0) ? EMIT : ACCUM;
                    end
                end
                ACCUM: begin
                    prod_rdy = 1'b1;
                    if (prod_val) begin
                        acc_d       = add_res;
                        remaining_d = remaining_q - 1'b1;
                        if (clamp) begin
                            ovf_d = 1'b1;
                        end
                        if (remaining_q == ELE_W'(1)) begin
                            state_d = EMIT;
                        end
                    end
                end
                EMIT: begin
                    y_val = 1'b1;
                    if (y_rdy) begin
                        row_idx_d = row_idx_q + 1'b1;
                        state_d   = (row_idx_q == nr_last) ? DONE : LOAD;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            nr_q        <= '0;
            row_idx_q   <= '0;
            remaining_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nr_q        <= nr_d;
            row_idx_q   <= row_idx_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign len_rdy = !fifo_full;
    assign y_data  = acc_q;
    assign y_row   = row_idx_q;
    assign y_last  = y_val && (row_idx_q == nr_last);
    assign done    = (state_q == DONE);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_spmv_row_reducer.sv
// Scoreboard bench for spmv_row_reducer: reference sums computed per row with plain integers.
// Accumulator narrowed to 40 bits so saturation/wrap is reachable with a few hundred products.
module tb_spmv_row_reducer;

    localparam int ELE_W = 32;
    localparam int ACC_W = 40;
    localparam int ROW_W = 16;

    localparam longint ACC_MOD = longint'(1) <<< ACC_W;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [ROW_W-1:0] row;
        logic             last;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             init;
    logic [ROW_W-1:0] nr;
    logic             len_val;
    logic             len_rdy;
    logic [ELE_W-1:0] len_data;
    logic             prod_val;
    logic             prod_rdy;
    logic [ELE_W-1:0] prod_data;
    logic             y_val;
    logic             y_rdy;
    logic [ACC_W-1:0] y_data;
    logic [ROW_W-1:0] y_row;
    logic             y_last;
    logic             done;
    logic             ovf;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];
    logic m_ovf      = 1'b0;
    bit   gap_en     = 1'b1;
    bit   rdy_random = 1'b1;
    bit   rdy_force  = 1'b1;

    always #5 clk = ~clk;

    spmv_row_reducer #(
        .ELE_W     (ELE_W),
        .ACC_W     (ACC_W),
        .ROW_W     (ROW_W),
        .LEN_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .nr        (nr),
        .len_val   (len_val),
        .len_rdy   (len_rdy),
        .len_data  (len_data),
        .prod_val  (prod_val),
        .prod_rdy  (prod_rdy),
        .prod_data (prod_data),
        .y_val     (y_val),
        .y_rdy     (y_rdy),
        .y_data    (y_data),
        .y_row     (y_row),
        .y_last    (y_last),
        .done      (done),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference addition: exact integer sum, then clamp or fold back into the ACC_W range.
    function automatic longint add_ref(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef SPMV_REDUCER_SAT_EN
        if (s > ACC_MAX) begin
            s     = ACC_MAX;
            m_ovf = 1'b1;
        end else if (s < ACC_MIN) begin
            s     = ACC_MIN;
            m_ovf = 1'b1;
        end
`else
        while (s > ACC_MAX) s = s - ACC_MOD;
        while (s < ACC_MIN) s = s + ACC_MOD;
`endif
        return s;
    endfunction

    task automatic model(input int n, input int unsigned l[$], input longint p[$]);
        longint acc;
        int     k;
        exp_t   e;
        k = 0;
        for (int r = 0; r < n; r++) begin
            acc = 0;
            for (int unsigned j = 0; j < l[r]; j++) begin
                acc = add_ref(acc, p[k]);
                k++;
            end
            e.data = acc[ACC_W-1:0];
            e.row  = ROW_W'(r);
            e.last = (r == n - 1);
            e.ovf  = m_ovf;
            sb.push_back(e);
        end
    endtask

    // Monitor: drives y_rdy for the coming edge, then checks whatever transfers on it.
    initial begin
        logic             hold_pending;
        logic [ACC_W-1:0] hold_data;
        logic [ROW_W-1:0] hold_row;
        logic             done_chk;
        exp_t             e;
        hold_pending = 1'b0;
        done_chk     = 1'b0;
        hold_data    = '0;
        hold_row     = '0;
        y_rdy        = 1'b1;
        forever begin
            @(negedge clk);
            y_rdy = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
            if (done_chk) begin
                chk("done_after_last", done, 1);
                done_chk = 1'b0;
            end
            if (hold_pending) begin
                chk("hold_y_val", y_val, 1);
                chk("hold_y_data", y_data, hold_data);
                chk("hold_y_row", y_row, hold_row);
                hold_pending = 1'b0;
            end
            if (y_val) begin
                chk("prod_rdy_in_emit", prod_rdy, 0);
                if (!y_rdy) begin
                    hold_pending = 1'b1;
                    hold_data    = y_data;
                    hold_row     = y_row;
                end else if (sb.size() == 0) begin
                    chk("unexpected_y", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("y_data", y_data, e.data);
                    chk("y_row", y_row, e.row);
                    chk("y_last", y_last, e.last);
                    chk("ovf", ovf, e.ovf);
                    chk("done_before_last", done, 0);
                    if (e.last) done_chk = 1'b1;
                end
            end
        end
    end

    task automatic send_lens(input int unsigned l[$]);
        bit ok;
        int t;
        foreach (l[i]) begin
            if (gap_en && ($urandom_range(0, 2) == 0)) begin
                len_val = 1'b0;
                @(negedge clk);
            end
            len_val  = 1'b1;
            len_data = l[i];
            ok = 1'b0;
            t  = 0;
            while (!ok) begin
                ok = len_rdy;
                @(negedge clk);
                t++;
                if (!ok && t > 2000) begin
                    chk("len_push_timeout", 1, 0);
                    break;
                end
            end
        end
        len_val = 1'b0;
    endtask

    task automatic send_prods(input longint p[$]);
        bit     ok;
        int     t;
        longint v;
        foreach (p[i]) begin
            if (gap_en && ($urandom_range(0, 3) == 0)) begin
                prod_val = 1'b0;
                @(negedge clk);
            end
            v         = p[i];
            prod_val  = 1'b1;
            prod_data = v[ELE_W-1:0];
            ok = 1'b0;
            t  = 0;
            while (!ok) begin
                ok = prod_rdy;
                @(negedge clk);
                t++;
                if (!ok && t > 2000) begin
                    chk("prod_push_timeout", 1, 0);
                    break;
                end
            end
        end
        prod_val = 1'b0;
    endtask

    task automatic do_init(input int n);
        init  = 1'b1;
        nr    = ROW_W'(n);
        m_ovf = 1'b0;
        @(negedge clk);
        init  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, done, 1);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic run_matrix(input int n, input int unsigned l[$], input longint p[$]);
        do_init(n);
        model(n, l, p);
        fork
            send_lens(l);
            send_prods(p);
        join
        wait_done("done_reached");
    endtask

    initial begin
        int unsigned lq[$];
        longint      pq[$];
        int          n;
        int          t;

        rst = 1'b1; init = 1'b0; nr = '0;
        len_val = 1'b0; len_data = '0; prod_val = 1'b0; prod_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_len_rdy", len_rdy, 1);
        chk("rst_prod_rdy", prod_rdy, 0);
        chk("rst_y_val", y_val, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_row", y_row, 0);
        chk("rst_y_last", y_last, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        // Basic two-row matrix.
        lq = '{3, 1};
        pq = '{5, -2, 7, -9};
        run_matrix(2, lq, pq);

        // Zero-length rows around a populated one.
        lq = '{0, 2, 0};
        pq = '{4, 4};
        run_matrix(3, lq, pq);

        // Back-pressure: hold y_rdy low while the length FIFO fills up.
        gap_en     = 1'b0;
        rdy_random = 1'b0;
        rdy_force  = 1'b0;
        lq = '{1, 1, 1, 1, 1};
        pq = '{};
        for (int i = 0; i < 5; i++) pq.push_back(longint'($signed($urandom())));
        do_init(5);
        model(5, lq, pq);
        fork
            send_lens(lq);
            send_prods(pq);
            begin
                t = 0;
                while (!y_val && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_y_val", y_val, 1);
                repeat (6) @(negedge clk);
                chk("bp_len_rdy_full", len_rdy, 0);
                chk("bp_prod_rdy", prod_rdy, 0);
                rdy_force = 1'b1;
            end
        join
        wait_done("bp_done");
        gap_en     = 1'b1;
        rdy_random = 1'b1;

        // Large same-sign rows drive the accumulator past both range limits.
        lq = '{260, 260};
        pq = '{};
        for (int i = 0; i < 260; i++) pq.push_back(64'sh7FFF_FFFF);
        for (int i = 0; i < 260; i++) pq.push_back(-64'sh8000_0000);
        run_matrix(2, lq, pq);

        // init in the middle of a row: partial sum and queued lengths are discarded.
        lq = '{4, 3};
        pq = '{11, 12};
        do_init(2);
        fork
            send_lens(lq);
            send_prods(pq);
        join
        repeat (2) @(negedge clk);
        chk("mid_accum_prod_rdy", prod_rdy, 1);
        lq = '{1};
        pq = '{6};
        run_matrix(1, lq, pq);

        // Empty matrix.
        do_init(0);
        chk("nr0_done_early", done, 0);
        @(negedge clk);
        chk("nr0_done", done, 1);
        chk("nr0_prod_rdy", prod_rdy, 0);
        chk("nr0_y_val", y_val, 0);

        // Randomised matrices.
        for (int m = 0; m < 8; m++) begin
            n = $urandom_range(1, 6);
            lq = '{};
            pq = '{};
            for (int r = 0; r < n; r++) begin
                lq.push_back($urandom_range(0, 5));
                for (int unsigned j = 0; j < lq[r]; j++) pq.push_back(longint'($signed($urandom())));
            end
            run_matrix(n, lq, pq);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
